life_step_ctrl: RTL and testbench

- Sequencer that owns port 1 (read-with-neighbours / write) of the Game-of-Life field RAM.
- On request, sweeps the field once in raster order and rewrites every cell with its next-generation state, applying the B3/S23 rule.
- Neighbour reads stay correct because each write is delayed by FIELD_W+2 cells behind the read pointer.
- While idle, it grants port 1 to a single-cell edit requester (cursor/pattern loader).
- Port 2 (display read) is not touched.

---
 rtl/life_step_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_life_step_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : life_step_ctrl
// Purpose  : Port-1 sequencer for the Game-of-Life field RAM. On request it
//            sweeps the field once in raster order, reading each cell with
//            its neighbours and writing the B3/S23 next state back. Writes
//            trail the reads by FIELD_W+2 cells, so every cell is rewritten
//            only after all cells that need its old value have been read.
//            While idle, port 1 belongs to a single-cell edit requester.
// Ports    : clk, rst_n (async, active-low)
//            i_start / o_busy / o_done            step request and status
//            i_edit_valid/x/y/state, o_edit_ready single-cell edit port
//            o_x_adr, o_y_adr, o_w_en, o_new_state RAM port-1 address/write
//            i_cell_state, i_nbrs                  RAM port-1 read data
//            o_gen_cnt                             generation counter
// Options  : LIFE_GEN_CNT_EN - when defined, o_gen_cnt counts completed
//            steps (16-bit, wrapping); otherwise o_gen_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module life_step_ctrl #(
  parameter  int FIELD_W        = 16,
  parameter  int FIELD_H        = 16,
  localparam int NEIGHBOURS_CNT = 8,
  localparam int X_ADR_SIZE     = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE     = $clog2(FIELD_H),
  localparam int DLY            = FIELD_W + 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  input  logic                      i_edit_valid,
  input  logic [X_ADR_SIZE-1:0]     i_edit_x,
  input  logic [Y_ADR_SIZE-1:0]     i_edit_y,
  input  logic                      i_edit_state,
  output logic                      o_edit_ready,
  output logic [X_ADR_SIZE-1:0]     o_x_adr,
  output logic [Y_ADR_SIZE-1:0]     o_y_adr,
  output logic                      o_w_en,
  output logic                      o_new_state,
  input  logic                      i_cell_state,
  input  logic [NEIGHBOURS_CNT-1:0] i_nbrs,
  output logic [15:0]               o_gen_cnt
);

  localparam int CNT_W = $clog2(DLY + 1);

  localparam logic [X_ADR_SIZE-1:0] c_x_last = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] c_y_last = Y_ADR_SIZE'(FIELD_H - 1);
  localparam logic [X_ADR_SIZE-1:0] c_x_one  = X_ADR_SIZE'(1);
  localparam logic [Y_ADR_SIZE-1:0] c_y_one  = Y_ADR_SIZE'(1);
  localparam logic [CNT_W-1:0]      c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      c_cnt_full = CNT_W'(DLY);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [X_ADR_SIZE-1:0] r_rx, r_wx;
  logic [Y_ADR_SIZE-1:0] r_ry, r_wy;
  // Delay line: newest result enters at bit 0. Oldest pending entry sits at
  // bit DLY-1 when the line is full, and at bit DLY-2 while draining.
  logic [DLY-1:0]        r_fifo;
  logic [CNT_W-1:0]      r_cnt;

  logic [3:0]            w_nbr_cnt;
  logic                  w_next;
  logic                  w_fifo_full;
  logic                  w_rd_last;
  logic                  w_wx_last, w_wy_last;

  always_comb begin
    w_nbr_cnt = 4'd0;
    for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
      w_nbr_cnt = w_nbr_cnt + {3'b000, i_nbrs[i]};
    end
  end

  assign w_next      = (w_nbr_cnt == 4'd3) | (i_cell_state & (w_nbr_cnt == 4'd2));
  assign w_fifo_full = (r_cnt == c_cnt_full);
  assign w_rd_last   = (r_rx == c_x_last) && (r_ry == c_y_last);
  assign w_wx_last   = (r_wx == c_x_last);
  assign w_wy_last   = (r_wy == c_y_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rx    <= '0;
      r_ry    <= '0;
      r_wx    <= '0;
      r_wy    <= '0;
      r_fifo  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // An edit owns the port this cycle; start waits for a free cycle.
          if (!i_edit_valid && i_start) begin
            r_state <= ST_RD;
            r_rx    <= '0;
            r_ry    <= '0;
            r_wx    <= '0;
            r_wy    <= '0;
            r_cnt   <= '0;
          end
        end
        ST_RD: begin
          r_fifo  <= {r_fifo[DLY-2:0], w_next};
          r_cnt   <= r_cnt + c_cnt_one;
          r_state <= ST_WR;
        end
        ST_WR: begin
          if (w_fifo_full) begin
            r_cnt <= r_cnt - c_cnt_one;
            if (w_wx_last) begin
              r_wx <= '0;
              r_wy <= w_wy_last ? '0 : r_wy + c_y_one;
            end else begin
              r_wx <= r_wx + c_x_one;
            end
          end
          if (w_rd_last) begin
            r_state <= ST_DRAIN;
          end else begin
            r_state <= ST_RD;
            if (r_rx == c_x_last) begin
              r_rx <= '0;
              r_ry <= r_ry + c_y_one;
            end else begin
              r_rx <= r_rx + c_x_one;
            end
          end
        end
        ST_DRAIN: begin
          r_fifo <= {r_fifo[DLY-2:0], 1'b0};
          r_cnt  <= r_cnt - c_cnt_one;
          if (w_wx_last) begin
            r_wx <= '0;
            r_wy <= w_wy_last ? '0 : r_wy + c_y_one;
          end else begin
            r_wx <= r_wx + c_x_one;
          end
          if (r_cnt == c_cnt_one) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Port-1 steering is decoded from the registered state and pointers; only
  // the idle edit path passes requester inputs straight through so the edit
  // lands on the same clock edge it is presented.
  always_comb begin
    o_x_adr     = '0;
    o_y_adr     = '0;
    o_w_en      = 1'b0;
    o_new_state = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_edit_valid) begin
          o_x_adr     = i_edit_x;
          o_y_adr     = i_edit_y;
          o_w_en      = 1'b1;
          o_new_state = i_edit_state;
        end
      end
      ST_RD: begin
        o_x_adr = r_rx;
        o_y_adr = r_ry;
      end
      ST_WR: begin
        o_x_adr     = r_wx;
        o_y_adr     = r_wy;
        o_w_en      = w_fifo_full;
        o_new_state = w_fifo_full & r_fifo[DLY-1];
      end
      ST_DRAIN: begin
        o_x_adr     = r_wx;
        o_y_adr     = r_wy;
        o_w_en      = 1'b1;
        o_new_state = r_fifo[DLY-2];
      end
      default: begin
      end
    endcase
  end

  assign o_busy       = (r_state == ST_RD) || (r_state == ST_WR) || (r_state == ST_DRAIN);
  assign o_done       = (r_state == ST_DONE);
  assign o_edit_ready = (r_state == ST_IDLE);

`ifdef LIFE_GEN_CNT_EN
  logic [15:0] r_gen_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gen_cnt <= 16'd0;
    end else if (r_state == ST_DONE) begin
      r_gen_cnt <= r_gen_cnt + 16'd1;
    end
  end

  assign o_gen_cnt = r_gen_cnt;
`else
  assign o_gen_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_life_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_step_ctrl
// Purpose  : Self-checking bench for life_step_ctrl on a 5x5 field. Holds a
//            behavioural field RAM for port 1, a generation-level reference
//            model (field, next generation, busy/done timeline) and one
//            compare process that checks the DUT every cycle, plus literal
//            pattern expectations (blinker, block, glider).
// Revision : 1.0 - initial release
// ============================================================================
module tb_life_step_ctrl;

  localparam int FW       = 5;
  localparam int FH       = 5;
  localparam int XW       = $clog2(FW);
  localparam int YW       = $clog2(FH);
  localparam int N        = FW * FH;
  localparam int DLY      = FW + 2;
  localparam int BUSY_LEN = 2 * N + DLY - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          o_busy, o_done;
  logic          i_edit_valid = 1'b0;
  logic [XW-1:0] i_edit_x = '0;
  logic [YW-1:0] i_edit_y = '0;
  logic          i_edit_state = 1'b0;
  logic          o_edit_ready;
  logic [XW-1:0] o_x_adr;
  logic [YW-1:0] o_y_adr;
  logic          o_w_en, o_new_state;
  logic          i_cell_state;
  logic [7:0]    i_nbrs;
  logic [15:0]   o_gen_cnt;

  life_step_ctrl #(.FIELD_W(FW), .FIELD_H(FH)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .i_edit_valid(i_edit_valid), .i_edit_x(i_edit_x), .i_edit_y(i_edit_y),
    .i_edit_state(i_edit_state), .o_edit_ready(o_edit_ready),
    .o_x_adr(o_x_adr), .o_y_adr(o_y_adr), .o_w_en(o_w_en), .o_new_state(o_new_state),
    .i_cell_state(i_cell_state), .i_nbrs(i_nbrs), .o_gen_cnt(o_gen_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- field RAM (environment, shares rst_n) ----------------
  logic ram [FH][FW];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) ram[y][x] <= 1'b0;
    end else if (o_w_en && int'(o_x_adr) < FW && int'(o_y_adr) < FH) begin
      ram[int'(o_y_adr)][int'(o_x_adr)] <= o_new_state;
    end
  end

  always_comb begin
    int k, xx, yy;
    logic b;
    k = 0; xx = 0; yy = 0; b = 1'b0;
    i_cell_state = 1'b0;
    i_nbrs = 8'd0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xx = int'(o_x_adr) + dx;
        yy = int'(o_y_adr) + dy;
        b = 1'b0;
        if (xx >= 0 && xx < FW && yy >= 0 && yy < FH) b = ram[yy][xx];
        if (dx == 0 && dy == 0) i_cell_state = b;
        else begin
          i_nbrs[k] = b;
          k = k + 1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  bit          m_field [FH][FW];
  bit          m_next  [FH][FW];
  bit          m_idle = 1'b1;
  bit          m_done = 1'b0;
  int          m_left = 0;
  int          m_step = 0;
  logic [15:0] m_gen  = 16'd0;
  int          m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_done = 1'b0; m_left = 0; m_gen = 16'd0;
      for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) m_field[y][x] = 1'b0;
    end else if (m_idle) begin
      if (i_edit_valid) begin
        m_field[int'(i_edit_y)][int'(i_edit_x)] = i_edit_state;
      end else if (i_start) begin
        m_idle = 1'b0;
        m_left = BUSY_LEN;
        m_step = m_step + 1;
        for (int y = 0; y < FH; y++) begin
          for (int x = 0; x < FW; x++) begin
            m_n = 0;
            for (int dy = -1; dy <= 1; dy++)
              for (int dx = -1; dx <= 1; dx++)
                if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < FW &&
                    y + dy >= 0 && y + dy < FH && m_field[y+dy][x+dx])
                  m_n = m_n + 1;
            m_next[y][x] = (m_n == 3) || (m_field[y][x] && m_n == 2);
          end
        end
      end
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) m_done = 1'b1;
    end else begin
      m_done = 1'b0;
      m_idle = 1'b1;
      m_gen  = m_gen + 16'd1;
      m_field = m_next;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int seen_step = 0;
  int wr_idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ram_at(input int x, input int y);
    return int'(ram[y][x]);
  endfunction

  function automatic int ram_pop();
    int c;
    c = 0;
    for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) c += int'(ram[y][x]);
    return c;
  endfunction

  task automatic edit(input int x, input int y, input bit s);
    bit ok;
    ok = 1'b0;
    i_edit_x = x[XW-1:0]; i_edit_y = y[YW-1:0]; i_edit_state = s; i_edit_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (o_edit_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    i_edit_valid = 1'b0;
    chk("edit_accepted", int'(ok), 1);
  endtask

  task automatic wait_done(output int busy_cyc);
    bit got;
    got = 1'b0; busy_cyc = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (o_busy) busy_cyc++;
      if (o_done) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    chk("done_seen", int'(got), 1);
  endtask

  task automatic step(output int busy_cyc);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done(busy_cyc);
  endtask

  task automatic reset_dut();
    @(posedge clk); #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int bc, dones;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (m_step != seen_step) begin seen_step = m_step; wr_idx = 0; end
        chk("busy", int'(o_busy), int'(!m_idle && m_left > 0));
        chk("done", int'(o_done), int'(m_done));
        chk("edit_ready", int'(o_edit_ready), int'(m_idle));
`ifdef LIFE_GEN_CNT_EN
        chk("gen_cnt", int'(o_gen_cnt), int'(m_gen));
`else
        chk("gen_cnt", int'(o_gen_cnt), 0);
`endif
        if (m_idle) begin
          chk("idle_wen", int'(o_w_en), int'(i_edit_valid));
          if (i_edit_valid) begin
            chk("edit_x", int'(o_x_adr), int'(i_edit_x));
            chk("edit_y", int'(o_y_adr), int'(i_edit_y));
            chk("edit_data", int'(o_new_state), int'(i_edit_state));
          end
        end else if (m_done) begin
          chk("done_wen", int'(o_w_en), 0);
          chk("wr_count", wr_idx, N);
        end else if (o_w_en) begin
          chk("wr_x_range", int'(int'(o_x_adr) < FW), 1);
          chk("wr_x", int'(o_x_adr), wr_idx % FW);
          chk("wr_y", int'(o_y_adr), (wr_idx / FW) % FH);
          chk("wr_val", int'(o_new_state), int'(m_next[(wr_idx / FW) % FH][wr_idx % FW]));
          wr_idx++;
        end
      end
    join_none

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_wen", int'(o_w_en), 0);
    chk("rst_x", int'(o_x_adr), 0);
    chk("rst_y", int'(o_y_adr), 0);
    chk("rst_gen", int'(o_gen_cnt), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // blinker
    edit(1, 2, 1'b1); edit(2, 2, 1'b1); edit(3, 2, 1'b1);
    step(bc);
    chk("blinker_busy_len", bc, 56);
    chk("blinker_21", ram_at(2, 1), 1);
    chk("blinker_22", ram_at(2, 2), 1);
    chk("blinker_23", ram_at(2, 3), 1);
    chk("blinker_pop", ram_pop(), 3);

    // block in the corner, two steps
    reset_dut();
    edit(0, 0, 1'b1); edit(1, 0, 1'b1); edit(0, 1, 1'b1); edit(1, 1, 1'b1);
    step(bc); step(bc);
    chk("block_00", ram_at(0, 0), 1);
    chk("block_11", ram_at(1, 1), 1);
    chk("block_pop", ram_pop(), 4);
`ifdef LIFE_GEN_CNT_EN
    chk("block_gen", int'(o_gen_cnt), 2);
`else
    chk("block_gen", int'(o_gen_cnt), 0);
`endif

    // edit and start together: edit first, step the following cycle
    reset_dut();
    i_edit_x = '0; i_edit_y = '0; i_edit_state = 1'b1; i_edit_valid = 1'b1; i_start = 1'b1;
    @(negedge clk);
    chk("es_wen", int'(o_w_en), 1);
    chk("es_busy0", int'(o_busy), 0);
    @(posedge clk); #1 i_edit_valid = 1'b0;
    @(negedge clk);
    chk("es_idle", int'(o_busy), 0);
    @(posedge clk); #1 i_start = 1'b0;
    @(negedge clk);
    chk("es_busy1", int'(o_busy), 1);
    wait_done(bc);
    chk("es_lone_cell_dies", ram_pop(), 0);

    // edit during busy lands only after DONE
    i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    edit(4, 4, 1'b1);
    chk("busy_edit_44", ram_at(4, 4), 1);
    chk("busy_edit_pop", ram_pop(), 1);

    // glider, four generations -> shifted by (+1,+1)
    reset_dut();
    edit(1, 0, 1'b1); edit(2, 1, 1'b1); edit(0, 2, 1'b1); edit(1, 2, 1'b1); edit(2, 2, 1'b1);
    repeat (4) step(bc);
    chk("glider_21", ram_at(2, 1), 1);
    chk("glider_32", ram_at(3, 2), 1);
    chk("glider_13", ram_at(1, 3), 1);
    chk("glider_23", ram_at(2, 3), 1);
    chk("glider_33", ram_at(3, 3), 1);
    chk("glider_pop", ram_pop(), 5);

    // random fields, steps interleaved with random edits
    reset_dut();
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        edit(x, y, 1'($urandom_range(0, 1)));
    for (int g = 0; g < 3; g++) begin
      step(bc);
      for (int e = 0; e < 3; e++)
        edit(int'($urandom_range(0, FW - 1)), int'($urandom_range(0, FH - 1)), 1'($urandom_range(0, 1)));
    end

    // reset mid-step
    i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_wen", int'(o_w_en), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(bc);
    chk("midrst_busy_len", bc, BUSY_LEN);
    chk("midrst_zero_field", ram_pop(), 0);

    // held start: three back-to-back generations
    for (int e = 0; e < 10; e++)
      edit(int'($urandom_range(0, FW - 1)), int'($urandom_range(0, FH - 1)), 1'b1);
    dones = 0;
    i_start = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (o_done) begin
        dones++;
        if (dones == 3) begin i_start = 1'b0; break; end
      end
    end
    i_start = 1'b0;
    chk("held_dones", dones, 3);
    repeat (4) begin
      @(negedge clk);
      chk("held_stopped", int'(o_busy), 0);
    end
`ifdef LIFE_GEN_CNT_EN
    chk("held_gen", int'(o_gen_cnt), 4);
`else
    chk("held_gen", int'(o_gen_cnt), 0);
`endif

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
